game_ctrl: RTL and testbench
============================

Name: game_ctrl

Overview:
- Top-level game sequencer for the snake design.
- Owns the IDLE/PLAY/PAUSE/OVER state machine and drives the score accumulator's control inputs: one-cycle apple_valid pulses, score_zero and the latched speed.
- Generates the snake step tick and tracks the session high score from the accumulator's binary score.
- Sits between the debounced buttons / snake collision logic and the score + display path.

Parameters:
- SLOW_DIV, 12500000, clk_mode cycles per move_tick when speed=0.
- FAST_DIV, 5000000, clk_mode cycles per move_tick when speed=1.
- CNT_W, 24, tick counter width; must satisfy 2^CNT_W > max(SLOW_DIV, FAST_DIV).
- SCORE_W, 14, width of score_in and high_score.

Ports:
- clk_mode  in  1  system clock; single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- btn_start  in  1  debounced one-cycle start pulse.
- btn_pause  in  1  debounced one-cycle pause/resume pulse.
- speed_sw  in  1  speed select switch (0 slow, 1 fast).
- eat  in  1  level from snake logic: head on apple.
- hit  in  1  level from snake logic: wall or self collision.
- score_in  in  SCORE_W  current binary score from the accumulator.
- apple_valid  out  1  one-cycle score increment request.
- score_zero  out  1  score clear request.
- speed  out  1  speed latched at game start.
- move_tick  out  1  one-cycle snake step strobe.
- game_state  out  2  0 IDLE, 1 PLAY, 2 PAUSE, 3 OVER.
- high_score  out  SCORE_W  best score since reset.
- new_record  out  1  last game set a new high score.

Behaviour:
- Reset: state IDLE, score_zero=1, apple_valid=0, speed=0, move_tick=0, high_score=0, new_record=0, tick counter=0, eat_q=0.
- rst_n takes effect immediately at any point, including mid-game; all registers return to reset values.
- All outputs are registered.

State machine:
- IDLE: score_zero=1 every cycle.
  - btn_start -> PLAY; speed<=speed_sw on the same edge.
  - btn_pause ignored, also when it coincides with btn_start.
- PLAY: score_zero=0.
  - hit -> OVER.
  - else btn_pause -> PAUSE.
  - btn_start ignored.
- PAUSE:
  - btn_pause -> PLAY.
  - btn_start, eat and hit ignored.
- OVER:
  - btn_start -> IDLE (score clears there); a new game needs a second btn_start.
  - btn_pause ignored.

Apple handshake:
- eat_q<=eat every cycle in every state.
- apple_valid<=1 for exactly one cycle, in the cycle after one where state==PLAY, eat=1, eat_q=0 and hit=0.
- A level held across PAUSE->PLAY generates no pulse.
- hit and an eat rising edge in the same cycle: hit wins, no pulse.
- Eats must be at least 2 cycles apart; the score module adds on every cycle apple_valid is high, so a pulse never exceeds one cycle.

Move tick:
- div = speed ? FAST_DIV : SLOW_DIV.
- In PLAY, the counter increments each cycle. At div-1 it wraps to 0 and move_tick=1 in the next cycle.
- PAUSE: counter holds its value and resumes from it.
- IDLE and OVER: counter forced to 0, move_tick=0.
- Entering OVER mid-count drops the pending tick.

High score:
- On the first cycle in OVER, if score_in > high_score, then high_score<=score_in and new_record<=1.
- Equal scores do not update.
- new_record clears on the OVER->IDLE transition.
- high_score is cleared only by rst_n, never by score_zero.

Widths:
- Counter compare is unsigned at CNT_W.
- Score compare is unsigned at SCORE_W.

Decomposition:
- Shared package game_pkg: state encodings (ST_IDLE=2'd0, ST_PLAY=2'd1, ST_PAUSE=2'd2, ST_OVER=2'd3), SCORE_W=14, increments 10 (slow) and 30 (fast).
- Sub-module move_tick_gen.
  - Inputs: clk_mode, rst_n, run, clear, speed.
  - Output: tick.
  - Parameters: SLOW_DIV/FAST_DIV/CNT_W.
- The FSM, edge detect and high-score logic stay in game_ctrl.

Test Plan (SLOW_DIV=8, FAST_DIV=4):
- Reset, then btn_start with speed_sw=1 -> game_state=1 next cycle, speed=1, score_zero=0; move_tick pulses every 4 cycles.
- In PLAY, eat high for 5 cycles -> apple_valid high exactly 1 cycle, one cycle after the eat rise; attached score module shows +30.
- btn_pause at counter=5 (speed 0), wait 20 cycles, btn_pause again -> no ticks in PAUSE; first tick 3 cycles after resume.
- hit and eat rise in the same cycle with score_in=120, high_score=0 -> no apple_valid; state OVER; high_score=120, new_record=1.
- Next game ending with score_in=90 -> high_score stays 120, new_record=0. btn_start in OVER -> IDLE, score_zero=1.
- rst_n low mid-PLAY for 1 cycle, asynchronously -> all outputs at reset values immediately, high_score=0.

Source files
------------

// File: rtl/game_pkg.sv
// game_pkg: shared state encodings and score constants for the snake game path.
package game_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_PAUSE = 2'd2,
    ST_OVER  = 2'd3
  } state_t;
  localparam int SCORE_W  = 14;
  localparam int INC_SLOW = 10;
  localparam int INC_FAST = 30;
endpackage

// File: rtl/move_tick_gen.sv
// move_tick_gen: speed-dependent snake step strobe; holds its count while run is low.
module move_tick_gen #(
  parameter int SLOW_DIV = 12500000,
  parameter int FAST_DIV = 5000000,
  parameter int CNT_W    = 24
) (
  input  logic clk_mode,
  input  logic rst_n,
  input  logic run,
  input  logic clear,
  input  logic speed,
  output logic tick
);
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] last;
  assign last = speed ? CNT_W'(FAST_DIV - 1) : CNT_W'(SLOW_DIV - 1);
  always_ff @(posedge clk_mode or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= run && !clear && cnt == last;
      cnt  <= clear ? '0 : !run ? cnt : cnt == last ? '0 : cnt + 1'b1;
    end
  end
endmodule

// File: rtl/game_ctrl.sv
// game_ctrl: IDLE/PLAY/PAUSE/OVER sequencer driving the score accumulator,
// snake step tick and session high score.
module game_ctrl
  import game_pkg::*;
#(
  parameter int SLOW_DIV = 12500000,
  parameter int FAST_DIV = 5000000,
  parameter int CNT_W    = 24,
  parameter int SCORE_W  = game_pkg::SCORE_W
) (
  input  logic               clk_mode,
  input  logic               rst_n,
  input  logic               btn_start,
  input  logic               btn_pause,
  input  logic               speed_sw,
  input  logic               eat,
  input  logic               hit,
  input  logic [SCORE_W-1:0] score_in,
  output logic               apple_valid,
  output logic               score_zero,
  output logic               speed,
  output logic               move_tick,
  output logic [1:0]         game_state,
  output logic [SCORE_W-1:0] high_score,
  output logic               new_record
);
  state_t state, nxt;
  logic eat_q, over_first, run, clear;
  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE:  nxt = btn_start ? ST_PLAY : ST_IDLE;
      ST_PLAY:  nxt = hit ? ST_OVER : btn_pause ? ST_PAUSE : ST_PLAY;
      ST_PAUSE: nxt = btn_pause ? ST_PLAY : ST_PAUSE;
      ST_OVER:  nxt = btn_start ? ST_IDLE : ST_OVER;
      default:  nxt = ST_IDLE;
    endcase
  end
  // A hit clears the counter on the same edge so no tick leaks into OVER.
  assign run   = state == ST_PLAY;
  assign clear = state == ST_IDLE || state == ST_OVER || (run && hit);
  assign game_state = state;
  always_ff @(posedge clk_mode or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      score_zero  <= 1'b1;
      apple_valid <= 1'b0;
      speed       <= 1'b0;
      high_score  <= '0;
      new_record  <= 1'b0;
      eat_q       <= 1'b0;
      over_first  <= 1'b0;
    end else begin
      state       <= nxt;
      eat_q       <= eat;
      score_zero  <= nxt == ST_IDLE;
      apple_valid <= run && eat && !eat_q && !hit;
      over_first  <= run && hit;
      if (state == ST_IDLE && btn_start) speed <= speed_sw;
      if (over_first && score_in > high_score) begin
        high_score <= score_in;
        new_record <= 1'b1;
      end else if (state == ST_OVER && btn_start) begin
        new_record <= 1'b0;
      end
    end
  end
  move_tick_gen #(.SLOW_DIV(SLOW_DIV), .FAST_DIV(FAST_DIV), .CNT_W(CNT_W)) u_tick (
    .clk_mode(clk_mode),
    .rst_n(rst_n),
    .run(run),
    .clear(clear),
    .speed(speed),
    .tick(move_tick)
  );
endmodule

// File: tb/tb_game_ctrl.sv
// tb_game_ctrl: directed checks of game_ctrl with a small attached score accumulator.
module tb_game_ctrl;
  import game_pkg::*;
  logic clk_mode = 1'b0, rst_n = 1'b0;
  logic btn_start = 0, btn_pause = 0, speed_sw = 0, eat = 0, hit = 0;
  logic [13:0] score_in, acc = '0, forced = '0;
  logic use_forced = 0;
  logic apple_valid, score_zero, speed, move_tick, new_record;
  logic [1:0] game_state;
  logic [13:0] high_score;
  int vecs = 0, errs = 0;

  always #5 clk_mode = ~clk_mode;

  game_ctrl #(.SLOW_DIV(8), .FAST_DIV(4), .CNT_W(4), .SCORE_W(14)) dut (
    .clk_mode(clk_mode), .rst_n(rst_n), .btn_start(btn_start), .btn_pause(btn_pause),
    .speed_sw(speed_sw), .eat(eat), .hit(hit), .score_in(score_in),
    .apple_valid(apple_valid), .score_zero(score_zero), .speed(speed),
    .move_tick(move_tick), .game_state(game_state), .high_score(high_score),
    .new_record(new_record)
  );

  always_ff @(posedge clk_mode)
    if (score_zero) acc <= '0;
    else if (apple_valid) acc <= acc + 14'(speed ? INC_FAST : INC_SLOW);
  assign score_in = use_forced ? forced : acc;

  task automatic cyc();
    @(posedge clk_mode);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_state"}, 32'(game_state), 0);
    chk({tag, "_zero"}, 32'(score_zero), 1);
    chk({tag, "_apple"}, 32'(apple_valid), 0);
    chk({tag, "_speed"}, 32'(speed), 0);
    chk({tag, "_tick"}, 32'(move_tick), 0);
    chk({tag, "_high"}, 32'(high_score), 0);
    chk({tag, "_rec"}, 32'(new_record), 0);
  endtask

  initial begin
    cyc(); cyc();
    chk_reset("reset");
    rst_n = 1'b1;
    // game 1: fast, start with a coincident pause that must be ignored
    speed_sw = 1; btn_start = 1; btn_pause = 1;
    cyc();
    btn_start = 0; btn_pause = 0;
    chk("g1_state", 32'(game_state), 1);
    chk("g1_speed", 32'(speed), 1);
    chk("g1_zero", 32'(score_zero), 0);
    for (int i = 1; i <= 8; i++) begin
      cyc();
      chk($sformatf("g1_tick%0d", i), 32'(move_tick), 32'(i % 4 == 0));
    end
    eat = 1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk($sformatf("g1_apple%0d", i), 32'(apple_valid), 32'(i == 0));
    end
    eat = 0;
    cyc();
    chk("g1_acc30", 32'(acc), 30);
    use_forced = 1; forced = 14'd120;
    hit = 1; eat = 1;
    cyc();
    hit = 0; eat = 0;
    chk("g1_hit_apple", 32'(apple_valid), 0);
    chk("g1_over", 32'(game_state), 3);
    cyc();
    chk("g1_high", 32'(high_score), 120);
    chk("g1_rec", 32'(new_record), 1);
    chk("g1_over_tick", 32'(move_tick), 0);
    btn_pause = 1;
    cyc();
    btn_pause = 0;
    chk("g1_over_pause", 32'(game_state), 3);
    btn_start = 1;
    cyc();
    btn_start = 0; use_forced = 0;
    chk("g1_idle", 32'(game_state), 0);
    chk("g1_idle_zero", 32'(score_zero), 1);
    chk("g1_idle_rec", 32'(new_record), 0);
    chk("g1_idle_high", 32'(high_score), 120);
    cyc();
    chk("g1_idle_stay", 32'(game_state), 0);
    // game 2: slow, pause with counter at 5
    speed_sw = 0; btn_start = 1;
    cyc();
    chk("g2_speed", 32'(speed), 0);
    for (int i = 0; i < 5; i++) begin
      cyc();
      btn_start = 0;
    end
    chk("g2_start_ignored", 32'(game_state), 1);
    btn_pause = 1;
    cyc();
    btn_pause = 0;
    chk("g2_pause", 32'(game_state), 2);
    eat = 1;
    for (int i = 0; i < 20; i++) begin
      btn_start = (i == 3); hit = (i == 7);
      cyc();
      chk($sformatf("g2_p_tick%0d", i), 32'(move_tick), 0);
      chk($sformatf("g2_p_state%0d", i), 32'(game_state), 2);
    end
    btn_start = 0; hit = 0;
    btn_pause = 1;
    cyc();
    btn_pause = 0;
    chk("g2_resume", 32'(game_state), 1);
    chk("g2_r_tick0", 32'(move_tick), 0);
    cyc();
    chk("g2_r_tick1", 32'(move_tick), 0);
    chk("g2_held_eat", 32'(apple_valid), 0);
    cyc();
    chk("g2_r_tick2", 32'(move_tick), 1);
    chk("g2_held_eat2", 32'(apple_valid), 0);
    eat = 0;
    use_forced = 1; forced = 14'd90; hit = 1;
    cyc();
    hit = 0;
    chk("g2_over", 32'(game_state), 3);
    cyc();
    chk("g2_high", 32'(high_score), 120);
    chk("g2_rec", 32'(new_record), 0);
    btn_start = 1;
    cyc();
    btn_start = 0; use_forced = 0;
    chk("g2_idle", 32'(game_state), 0);
    chk("g2_idle_zero", 32'(score_zero), 1);
    // game 3: asynchronous reset mid-play
    speed_sw = 1; btn_start = 1;
    cyc();
    btn_start = 0;
    cyc(); cyc();
    chk("g3_play", 32'(game_state), 1);
    chk("g3_speed", 32'(speed), 1);
    #3 rst_n = 1'b0;
    #1 chk_reset("async");
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("post_reset_state", 32'(game_state), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
